// File: rtl/secuenciador_iir_biquad.sv
// -----------------------------------------------------------------------------
// secuenciador_iir_biquad
// Sequencer for a shared single-MAC IIR biquad low-pass datapath. For every
// rising edge of the ADC sample flag it walks a fixed 5-product schedule:
//   recursive part : fk = Uk + c0*fk_1 + c1*fk_2
//   output part    : Yk = c2*fk + c3*fk_1 + c4*fk_2
// and drives the datapath mux selects and register strobes.
//
// Ports
//   i_Clk            system clock, rising edge
//   i_Reset_n        synchronous active-low reset
//   i_Bandera_ADC    sample-valid level; rising edge requests one iteration
//   i_Habilitar      filter enable, only looked at while idle
//   i_Limpiar        clears o_Sobrecarga
//   o_Sel_Const      constant select 0..4 = c0..c4
//   o_Sel_Fk         multiplicand select 0=fk 1=fk_1 2=fk_2
//   o_Sel_Acum       adder addend 1=Uk 0=accumulator
//   o_Acum_En        accumulator load strobe
//   o_Acum_Clr       accumulator synchronous clear
//   o_Shift_En       fk history shift (fk_2<=fk_1, fk_1<=fk, fk<=acc)
//   o_Bandera_Listo  one-cycle pulse, Yk valid
//   o_Ocupado        sequence in progress
//   o_Sobrecarga     sticky overrun flag
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a sample edge
// S_A1    | acc <= Uk + c0*fk_1
// S_A2    | acc <= acc + c1*fk_2
// S_SHIFT | fk history shifts in the new fk, accumulator cleared
// S_B0    | acc <= acc + c2*fk
// S_B1    | acc <= acc + c3*fk_1
// S_B2    | acc <= acc + c4*fk_2
// S_DONE  | Yk valid pulse
// -----------------------------------------------------------------------------
module secuenciador_iir_biquad #(
    parameter int STEP_CYC = 2,
    parameter int CNT_W    = 3
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Bandera_ADC,
    input  logic       i_Habilitar,
    input  logic       i_Limpiar,
    output logic [2:0] o_Sel_Const,
    output logic [1:0] o_Sel_Fk,
    output logic       o_Sel_Acum,
    output logic       o_Acum_En,
    output logic       o_Acum_Clr,
    output logic       o_Shift_En,
    output logic       o_Bandera_Listo,
    output logic       o_Ocupado,
    output logic       o_Sobrecarga
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A1    = 3'd1,
        S_A2    = 3'd2,
        S_SHIFT = 3'd3,
        S_B0    = 3'd4,
        S_B1    = 3'd5,
        S_B2    = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STEP_CYC - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_prev;

    logic               w_start;
    logic               w_last;
    logic               w_nxt_mac;
    state_t             w_nxt_state;
    logic [CNT_W-1:0]   w_nxt_cnt;

    assign w_start = i_Bandera_ADC & ~r_prev;
    assign w_last  = (r_cnt == LP_LAST);

    // Next state / next counter. Outputs are registered from these so that
    // they line up with the state they describe.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start && i_Habilitar) w_nxt_state = S_A1;
            end
            S_A1: begin
                if (w_last) w_nxt_state = S_A2;
                else        w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
            S_A2: begin
                if (w_last) w_nxt_state = S_SHIFT;
                else        w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
            S_SHIFT: w_nxt_state = S_B0;
            S_B0: begin
                if (w_last) w_nxt_state = S_B1;
                else        w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
            S_B1: begin
                if (w_last) w_nxt_state = S_B2;
                else        w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
            S_B2: begin
                if (w_last) w_nxt_state = S_DONE;
                else        w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
            S_DONE:  w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    assign w_nxt_mac = (w_nxt_state == S_A1) || (w_nxt_state == S_A2) ||
                       (w_nxt_state == S_B0) || (w_nxt_state == S_B1) ||
                       (w_nxt_state == S_B2);

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_prev          <= 1'b1;   // a level already high at release is not an edge
            o_Sel_Const     <= 3'd0;
            o_Sel_Fk        <= 2'd0;
            o_Sel_Acum      <= 1'b1;
            o_Acum_En       <= 1'b0;
            o_Acum_Clr      <= 1'b0;
            o_Shift_En      <= 1'b0;
            o_Bandera_Listo <= 1'b0;
            o_Ocupado       <= 1'b0;
            o_Sobrecarga    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_prev    <= i_Bandera_ADC;

            o_Sel_Const     <= 3'd0;
            o_Sel_Fk        <= 2'd0;
            o_Sel_Acum      <= 1'b0;
            o_Acum_Clr      <= 1'b0;
            o_Shift_En      <= 1'b0;
            o_Bandera_Listo <= 1'b0;
            o_Ocupado       <= (w_nxt_state != S_IDLE);
            o_Acum_En       <= w_nxt_mac && (w_nxt_cnt == LP_LAST);
            case (w_nxt_state)
                S_IDLE:  o_Sel_Acum <= 1'b1;
                S_A1: begin
                    o_Sel_Fk   <= 2'd1;
                    o_Sel_Acum <= 1'b1;
                end
                S_A2: begin
                    o_Sel_Const <= 3'd1;
                    o_Sel_Fk    <= 2'd2;
                end
                S_SHIFT: begin
                    o_Shift_En <= 1'b1;
                    o_Acum_Clr <= 1'b1;
                end
                S_B0:    o_Sel_Const <= 3'd2;
                S_B1: begin
                    o_Sel_Const <= 3'd3;
                    o_Sel_Fk    <= 2'd1;
                end
                S_B2: begin
                    o_Sel_Const <= 3'd4;
                    o_Sel_Fk    <= 2'd2;
                end
                S_DONE: begin
                    o_Sel_Acum      <= 1'b1;
                    o_Bandera_Listo <= 1'b1;
                end
                default: o_Sel_Acum <= 1'b1;
            endcase

            // A request arriving outside IDLE is dropped; set beats clear.
            if (w_start && (r_state != S_IDLE)) o_Sobrecarga <= 1'b1;
            else if (i_Limpiar)                 o_Sobrecarga <= 1'b0;
        end
    end

endmodule

// File: tb/tb_secuenciador_iir_biquad.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_iir_biquad
// Directed bench for secuenciador_iir_biquad. Two instances share clock, reset,
// enable and clear: u_dut2 with STEP_CYC=2, u_dut1 with STEP_CYC=1.
// Output bundle layout: {Sel_Const[2:0], Sel_Fk[1:0], Sel_Acum, Acum_En,
//                        Acum_Clr, Shift_En, Bandera_Listo, Ocupado}
// -----------------------------------------------------------------------------
module tb_secuenciador_iir_biquad;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, adc, adc1, hab, lim;

    logic [2:0] sc2, sc1;
    logic [1:0] sf2, sf1;
    logic sa2, en2, clr2, sh2, lst2, ocp2, sob2;
    logic sa1, en1, clr1, sh1, lst1, ocp1, sob1;

    secuenciador_iir_biquad #(.STEP_CYC(2), .CNT_W(3)) u_dut2 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Bandera_ADC(adc), .i_Habilitar(hab),
        .i_Limpiar(lim), .o_Sel_Const(sc2), .o_Sel_Fk(sf2), .o_Sel_Acum(sa2),
        .o_Acum_En(en2), .o_Acum_Clr(clr2), .o_Shift_En(sh2),
        .o_Bandera_Listo(lst2), .o_Ocupado(ocp2), .o_Sobrecarga(sob2)
    );

    secuenciador_iir_biquad #(.STEP_CYC(1), .CNT_W(3)) u_dut1 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Bandera_ADC(adc1), .i_Habilitar(hab),
        .i_Limpiar(lim), .o_Sel_Const(sc1), .o_Sel_Fk(sf1), .o_Sel_Acum(sa1),
        .o_Acum_En(en1), .o_Acum_Clr(clr1), .o_Shift_En(sh1),
        .o_Bandera_Listo(lst1), .o_Ocupado(ocp1), .o_Sobrecarga(sob1)
    );

    logic [10:0] b2, b1;
    assign b2 = {sc2, sf2, sa2, en2, clr2, sh2, lst2, ocp2};
    assign b1 = {sc1, sf1, sa1, en1, clr1, sh1, lst1, ocp1};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [10:0] mk(input logic [2:0] c, input logic [1:0] f,
                                       input logic a, input logic e, input logic cl,
                                       input logic sh, input logic l, input logic o);
        return {c, f, a, e, cl, sh, l, o};
    endfunction

    function automatic logic [10:0] idle_b();
        return mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Expected bundle k cycles after the start edge, STEP_CYC=2
    function automatic logic [10:0] exp2(input int k);
        case (k)
            1:  return mk(3'd0, 2'd1, 1, 0, 0, 0, 0, 1);
            2:  return mk(3'd0, 2'd1, 1, 1, 0, 0, 0, 1);
            3:  return mk(3'd1, 2'd2, 0, 0, 0, 0, 0, 1);
            4:  return mk(3'd1, 2'd2, 0, 1, 0, 0, 0, 1);
            5:  return mk(3'd0, 2'd0, 0, 0, 1, 1, 0, 1);
            6:  return mk(3'd2, 2'd0, 0, 0, 0, 0, 0, 1);
            7:  return mk(3'd2, 2'd0, 0, 1, 0, 0, 0, 1);
            8:  return mk(3'd3, 2'd1, 0, 0, 0, 0, 0, 1);
            9:  return mk(3'd3, 2'd1, 0, 1, 0, 0, 0, 1);
            10: return mk(3'd4, 2'd2, 0, 0, 0, 0, 0, 1);
            11: return mk(3'd4, 2'd2, 0, 1, 0, 0, 0, 1);
            12: return mk(3'd0, 2'd0, 1, 0, 0, 0, 1, 1);
            default: return idle_b();
        endcase
    endfunction

    // Expected bundle k cycles after the start edge, STEP_CYC=1
    function automatic logic [10:0] exp1(input int k);
        case (k)
            1: return mk(3'd0, 2'd1, 1, 1, 0, 0, 0, 1);
            2: return mk(3'd1, 2'd2, 0, 1, 0, 0, 0, 1);
            3: return mk(3'd0, 2'd0, 0, 0, 1, 1, 0, 1);
            4: return mk(3'd2, 2'd0, 0, 1, 0, 0, 0, 1);
            5: return mk(3'd3, 2'd1, 0, 1, 0, 0, 0, 1);
            6: return mk(3'd4, 2'd2, 0, 1, 0, 0, 0, 1);
            7: return mk(3'd0, 2'd0, 1, 0, 0, 0, 1, 1);
            default: return idle_b();
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; adc = 1'b0; adc1 = 1'b0; hab = 1'b1; lim = 1'b0;
        tick; tick; tick;
        chk("reset_bundle2", b2, idle_b());
        chk("reset_bundle1", b1, idle_b());
        chk("reset_sob", 11'(sob2), 11'd0);
        rst_n = 1'b1;
        while (cyc < 10) tick;

        // Single sample at cycle 10, second rise at cycle 15 -> overrun
        adc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            chk($sformatf("seqA k=%0d", k), b2, exp2(k));
            chk($sformatf("seqA_sob k=%0d", k), 11'(sob2), 11'((k >= 6) ? 1 : 0));
            if (k == 2) adc = 1'b0;
            if (k == 5) adc = 1'b1;
        end
        tick;
        chk("seqA_after", b2, idle_b());
        adc = 1'b0;
        while (cyc < 30) tick;
        chk("sob_before_clear", 11'(sob2), 11'd1);
        lim = 1'b1;
        tick;
        lim = 1'b0;
        chk("sob_after_clear", 11'(sob2), 11'd0);

        // Disabled: edge in IDLE is ignored
        hab = 1'b0;
        tick;
        adc = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk($sformatf("disabled k=%0d", k), b2, idle_b());
            chk($sformatf("disabled_sob k=%0d", k), 11'(sob2), 11'd0);
        end
        adc = 1'b0;
        hab = 1'b1;
        tick;

        // Back-to-back: start in first IDLE after DONE, Habilitar drop ignored
        adc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            chk($sformatf("seqB k=%0d", k), b2, exp2(k));
            if (k == 2) begin adc = 1'b0; hab = 1'b0; end
        end
        hab = 1'b1;
        tick;
        chk("seqB_idle", b2, idle_b());
        adc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            chk($sformatf("seqC k=%0d", k), b2, exp2(k));
            chk($sformatf("seqC_sob k=%0d", k), 11'(sob2), 11'((k >= 5 && k < 8) ? 1 : 0));
            lim = 1'b0;
            if (k == 2) adc = 1'b0;
            if (k == 4) begin adc = 1'b1; lim = 1'b1; end
            if (k == 7) lim = 1'b1;
            if (k == 8) adc = 1'b0;
            if (k == 12) adc = 1'b1;
        end
        tick;
        chk("done_start_dropped", b2, idle_b());
        chk("done_start_sob", 11'(sob2), 11'd1);
        adc = 1'b0;
        lim = 1'b1;
        tick;
        lim = 1'b0;
        chk("sob_clear2", 11'(sob2), 11'd0);

        // Reset in the middle of a sequence with the ADC flag held high
        adc = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            chk($sformatf("seqR k=%0d", k), b2, exp2(k));
        end
        rst_n = 1'b0;
        tick;
        chk("midreset_idle", b2, idle_b());
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk($sformatf("no_restart k=%0d", k), b2, idle_b());
        end
        adc = 1'b0;
        tick;
        adc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            chk($sformatf("seqR2 k=%0d", k), b2, exp2(k));
            if (k == 2) adc = 1'b0;
        end

        // STEP_CYC=1 instance
        adc1 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick;
            chk($sformatf("step1 k=%0d", k), b1, exp1(k));
        end
        adc1 = 1'b0;
        tick;
        chk("step1_after", b1, idle_b());
        chk("step1_sob", 11'(sob1), 11'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/secuenciador_iir_biquad.md
Name: secuenciador_iir_biquad

Overview:
- Sequencer for the shared single-MAC IIR low-pass datapath (constant mux, fk/fk_1/fk_2 mux, Uk/accumulator mux, multiply-add, accumulator, fk shift register).
- Per ADC sample, runs a fixed 5-product schedule:
  - recursive part: fk = Uk + c0·fk_1 + c1·fk_2
  - output part: Yk = c2·fk + c3·fk_1 + c4·fk_2
- Drives all mux selects and register strobes, and flags the finished sample and any sample overrun.

Parameters:
- STEP_CYC, 2, cycles each MAC step is held before the accumulator captures (covers mux+multiplier settle); legal 1..8.
- CNT_W, 3, width of the step-cycle counter; must satisfy 2^CNT_W ≥ STEP_CYC.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  synchronous, active-low reset
- Bandera_ADC  in  1  ADC sample-valid level; rising edge requests one filter iteration
- Habilitar  in  1  filter enable; sampled only in IDLE
- Limpiar  in  1  clears Sobrecarga
- Sel_Const  out  3  constant select: 0=c0(-a1) 1=c1(-a2) 2=c2(b0) 3=c3(b1) 4=c4(b2)
- Sel_Fk  out  2  multiplicand select: 0=fk 1=fk_1 2=fk_2
- Sel_Acum  out  1  adder addend: 1=Uk, 0=accumulator
- Acum_En  out  1  accumulator load strobe
- Acum_Clr  out  1  accumulator synchronous clear
- Shift_En  out  1  fk_2<=fk_1, fk_1<=fk, fk<=accumulator
- Bandera_Listo  out  1  one-cycle pulse, Yk valid
- Ocupado  out  1  sequence in progress
- Sobrecarga  out  1  sticky overrun flag

Behaviour:
- Reset (Reset_n=0 at a clock edge):
  - state=IDLE, step counter=0.
  - Edge-detect register = 1, so a level already high at reset release does not start a sequence.
  - All outputs 0 except Sel_Acum=1.
  - Reset mid-sequence aborts immediately; no Bandera_Listo.
- Edge detect: start = Bandera_ADC & ~prev; prev is updated every cycle.
- IDLE: Ocupado=0, strobes 0.
  - start & Habilitar → S_A1.
  - start & ~Habilitar → stay in IDLE, no flag.
- MAC step states, each held exactly STEP_CYC cycles:
  - Acum_En=1 on the last cycle of the step only.
  - Counter resets to 0 on step entry.
  - Selects are stable for the whole step.
- S_A1: Sel_Const=0, Sel_Fk=1, Sel_Acum=1 → S_A2.
- S_A2: Sel_Const=1, Sel_Fk=2, Sel_Acum=0 → S_SHIFT.
- S_SHIFT (1 cycle): Shift_En=1, Acum_Clr=1, selects 0 → S_B0.
- S_B0: Sel_Const=2, Sel_Fk=0, Sel_Acum=0 → S_B1.
- S_B1: Sel_Const=3, Sel_Fk=1, Sel_Acum=0 → S_B2.
- S_B2: Sel_Const=4, Sel_Fk=2, Sel_Acum=0 → S_DONE.
- S_DONE (1 cycle): Bandera_Listo=1, selects 0, Sel_Acum=1 → IDLE.
- Ocupado=1 in every state except IDLE.
- Latency: start seen at cycle t → S_A1 entered at t+1 → Bandera_Listo at t+5·STEP_CYC+2 (t+12 for default).
- Sel_Const codes 5..7 are never driven.
- Illegal or unreachable state encoding → IDLE on the next cycle, no strobes.
- Overrun: start while state≠IDLE (including S_DONE) sets Sobrecarga.
  - The request is dropped; the current sequence is unaffected.
  - Back-to-back samples are accepted only from IDLE; a start in the first IDLE cycle after S_DONE is accepted.
- Sobrecarga:
  - Cleared by Limpiar=1 or reset.
  - Set and Limpiar in the same cycle → set wins.
- Habilitar falling mid-sequence: ignored; the sequence completes and Bandera_Listo fires.
- Strobe exclusivity: Acum_En, Acum_Clr and Shift_En are never high in the same cycle.

Test Plan:
- Reset, then single Bandera_ADC rise at t=10, Habilitar=1, STEP_CYC=2:
  - Sel_Const/Sel_Fk sequence 0/1,1/2,(S_SHIFT),2/0,3/1,4/2, each held 2 cycles.
  - Acum_En at t=12,14,17,19,21; Shift_En+Acum_Clr at t=15; Bandera_Listo only at t=22; Ocupado t=11..22.
- Second rise at t=15 during sequence → Sobrecarga=1 from t=16.
  - Only one Bandera_Listo (t=22).
  - Limpiar pulse at t=30 → Sobrecarga=0 at t=31.
- Habilitar=0 with Bandera_ADC rise in IDLE → no state change, Ocupado stays 0, Sobrecarga stays 0.
- Reset_n=0 at t=16 mid-sequence with Bandera_ADC held high:
  - All outputs idle next cycle; no Bandera_Listo.
  - No restart after release until Bandera_ADC falls and rises again.
- STEP_CYC=1 build: rise at t=5 → Bandera_Listo at t=12; Acum_En every MAC cycle.
- Rise in the first IDLE cycle after S_DONE → accepted, no overrun.
- Limpiar coincident with an overrun start → Sobrecarga=1.
